// File: rtl/ca_generation_engine.sv
// Sequential driver for a 1-D cellular-automaton ring: applies a 4-bit neighbour
// rule once per clock for a latched generation count, stopping early on a fixed point.
module ca_generation_engine #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] seed,
  input  logic [3:0]       rule,
  input  logic [CNT_W-1:0] gens,
  output logic [WIDTH-1:0] state,
  output logic [CNT_W-1:0] gen_count,
  output logic             busy,
  output logic             done,
  output logic             fixed_pt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fsm_t;

  fsm_t             r_fsm;
  fsm_t             w_fsm_nxt;
  logic [WIDTH-1:0] r_state;
  logic [CNT_W-1:0] r_gen_count;
  logic [3:0]       r_rule;
  logic [CNT_W-1:0] r_gens;
  logic             r_fixed_pt;

  logic [WIDTH-1:0] w_next;
  logic [CNT_W-1:0] w_gen_inc;
  logic             w_load;
  logic             w_step;
  logic             w_fix;

  // Each cell looks at itself and its left-hand neighbour; cell WIDTH-1 wraps to cell 0.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    w_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_next[i] = r_rule[{r_state[(i + 1) % WIDTH], r_state[i]}];
    end
  end

  assign w_gen_inc = r_gen_count + 1'b1;

  always_comb begin
    w_fsm_nxt = r_fsm;
    w_load    = 1'b0;
    w_step    = 1'b0;
    w_fix     = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        if (start) begin
          w_load    = 1'b1;
          w_fsm_nxt = (gens == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_fsm_nxt = S_IDLE;
        end else if (w_next == r_state) begin
          w_fix     = 1'b1;
          w_fsm_nxt = S_DONE;
        end else begin
          w_step = 1'b1;
          if (w_gen_inc == r_gens) w_fsm_nxt = S_DONE;
        end
      end
      S_DONE:  w_fsm_nxt = S_IDLE;
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) r_fsm <= S_IDLE;
    else       r_fsm <= w_fsm_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= '0;
      r_gen_count <= '0;
      r_rule      <= '0;
      r_gens      <= '0;
      r_fixed_pt  <= 1'b0;
    end else if (w_load) begin
      r_state     <= seed;
      r_gen_count <= '0;
      r_rule      <= rule;
      r_gens      <= gens;
      r_fixed_pt  <= 1'b0;
    end else if (w_step) begin
      r_state     <= w_next;
      r_gen_count <= w_gen_inc;
    end else if (w_fix) begin
      r_fixed_pt  <= 1'b1;
    end
  end

  assign state     = r_state;
  assign gen_count = r_gen_count;
  assign busy      = (r_fsm == S_RUN);
  assign done      = (r_fsm == S_DONE);
  assign fixed_pt  = r_fixed_pt;

endmodule

// File: tb/tb_ca_generation_engine.sv
// Directed-vector bench for ca_generation_engine; expected values are hand-derived
// from the neighbour-rule definition and the documented cycle latencies.
module tb_ca_generation_engine;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] seed;
  logic [3:0] rule;
  logic [7:0] gens;
  logic [7:0] state;
  logic [7:0] gen_count;
  logic       busy;
  logic       done;
  logic       fixed_pt;

  int n_vec;
  int n_err;

  ca_generation_engine #(.WIDTH(8), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .seed      (seed),
    .rule      (rule),
    .gens      (gens),
    .state     (state),
    .gen_count (gen_count),
    .busy      (busy),
    .done      (done),
    .fixed_pt  (fixed_pt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] s, input logic [3:0] r, input logic [7:0] g);
    seed  = s;
    rule  = r;
    gens  = g;
    start = 1'b1;
    tick();
    start = 1'b0;
    seed  = 8'h00;
    rule  = 4'h0;
    gens  = 8'h00;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    start = 1'b1;
    abort = 1'b0;
    seed  = 8'hA5;
    rule  = 4'hF;
    gens  = 8'h07;
    tick();
    tick();
    check("rst_state", state, 8'h00);
    check("rst_gc", gen_count, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_fp", fixed_pt, 1'b0);
    reset = 1'b0;
    start = 1'b0;
    tick();

    // 1: XOR rule, one generation
    launch(8'h01, 4'b0110, 8'd1);
    check("t1_seed", state, 8'h01);
    check("t1_busy", busy, 1'b1);
    tick();
    check("t1_done", done, 1'b1);
    check("t1_state", state, 8'h81);
    check("t1_gc", gen_count, 8'd1);
    check("t1_fp", fixed_pt, 1'b0);
    tick();
    check("t1_done_drop", done, 1'b0);

    // 2: rotate right for three generations
    launch(8'h01, 4'b1100, 8'd3);
    tick();
    check("t2_s1", state, 8'h80);
    check("t2_nd1", done, 1'b0);
    tick();
    check("t2_s2", state, 8'h40);
    tick();
    check("t2_s3", state, 8'h20);
    check("t2_done", done, 1'b1);
    check("t2_gc", gen_count, 8'd3);
    tick();

    // 3: all-zero rule reaches a fixed point after one update
    launch(8'hFF, 4'b0000, 8'd5);
    tick();
    check("t3_state", state, 8'h00);
    check("t3_nd", done, 1'b0);
    tick();
    check("t3_done", done, 1'b1);
    check("t3_fp", fixed_pt, 1'b1);
    check("t3_gc", gen_count, 8'd1);
    tick();
    check("t3_fp_hold", fixed_pt, 1'b1);

    // 4: identity rule is a fixed point immediately
    launch(8'h5A, 4'b1010, 8'd4);
    check("t4_fp_clr", fixed_pt, 1'b0);
    tick();
    check("t4_done", done, 1'b1);
    check("t4_fp", fixed_pt, 1'b1);
    check("t4_gc", gen_count, 8'd0);
    check("t4_state", state, 8'h5A);
    tick();

    // 5: zero generations goes straight to DONE
    launch(8'hC3, 4'b0110, 8'd0);
    check("t5_done", done, 1'b1);
    check("t5_busy", busy, 1'b0);
    check("t5_state", state, 8'hC3);
    check("t5_fp", fixed_pt, 1'b0);
    tick();
    check("t5_busy2", busy, 1'b0);
    check("t5_done2", done, 1'b0);

    // 5b: a start pulse during RUN is ignored
    launch(8'h01, 4'b1100, 8'd3);
    seed  = 8'hFF;
    rule  = 4'b0110;
    gens  = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5b_s1", state, 8'h80);
    tick();
    tick();
    check("t5b_done", done, 1'b1);
    check("t5b_state", state, 8'h20);
    tick();

    // 6: abort mid-run keeps state and never pulses done
    launch(8'h01, 4'b1100, 8'd10);
    tick();
    tick();
    check("t6_pre", state, 8'h40);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_busy", busy, 1'b0);
    check("t6_done", done, 1'b0);
    check("t6_state", state, 8'h40);
    check("t6_gc", gen_count, 8'd2);
    tick();
    check("t6_done2", done, 1'b0);
    check("t6_hold", state, 8'h40);

    // 6b: reset mid-run clears everything
    launch(8'h01, 4'b1100, 8'd10);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6b_state", state, 8'h00);
    check("t6b_gc", gen_count, 8'd0);
    check("t6b_busy", busy, 1'b0);
    check("t6b_done", done, 1'b0);
    tick();
    check("t6b_idle", busy, 1'b0);

    // held start re-triggers on the IDLE cycle after DONE
    seed  = 8'h01;
    rule  = 4'b0110;
    gens  = 8'd1;
    start = 1'b1;
    tick();
    check("rt_busy", busy, 1'b1);
    tick();
    check("rt_done", done, 1'b1);
    check("rt_state", state, 8'h81);
    tick();
    check("rt_idle", busy, 1'b0);
    tick();
    start = 1'b0;
    check("rt_again", busy, 1'b1);
    check("rt_seed", state, 8'h01);
    tick();
    tick();

    // max generation count: 255 right-rotations of 01 leaves 02
    launch(8'h01, 4'b1100, 8'd255);
    begin
      int waited;
      waited = 0;
      while (!done && waited < 300) begin
        tick();
        waited++;
      end
      check("max_latency", waited, 255);
    end
    check("max_state", state, 8'h02);
    check("max_gc", gen_count, 8'd255);
    check("max_fp", fixed_pt, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
